// File: rtl/iter_lshift_unit.sv
// ---------------------------------------------------------------------------
// iter_lshift_unit
//
// Multi-cycle logical left shifter with valid/ready handshakes on both sides.
// An accepted operand is shifted left by one bit per clock until the
// requested amount is reached. The result is then held for the downstream
// consumer until it is taken. Only one request is in flight at a time.
//
// Optional feature macro: ITER_SHIFT_OVF_EN
//   When defined, the out_ovf port exists. It is a sticky flag for each
//   operation that reports whether any 1 bit was shifted out of the MSB.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   request valid (operand + amount)
//   in_ready   unit can accept a request (IDLE only)
//   in_data    operand, WIDTH bits
//   in_amt     unsigned shift amount, SHW bits
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   out_data   shifted result; holds the last result outside DONE
//   out_ovf    overflow flag (ITER_SHIFT_OVF_EN only), valid with out_valid
// ---------------------------------------------------------------------------
module iter_lshift_unit #(
    parameter int WIDTH = 8,
    parameter int SHW   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef ITER_SHIFT_OVF_EN
    ,
    output logic             out_ovf
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    // WIDTH widened past the amount port, so the clamp compare is exact
    // whatever the relative sizes of SHW and WIDTH are.
    localparam logic [SHW+31:0] WIDTH_EXT = WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;   // working shift register
    logic [WIDTH-1:0] res_q, res_d;     // presented result, stable outside DONE
    logic [CW-1:0]    cnt_q, cnt_d;     // remaining single-bit shifts

    logic amt_big;
    logic amt_zero;

    assign amt_big  = ({32'd0, in_amt} >= WIDTH_EXT);
    assign amt_zero = (in_amt == '0);

`ifdef ITER_SHIFT_OVF_EN
    logic ovf_q, ovf_d;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            data_q  <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
`ifdef ITER_SHIFT_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
`ifdef ITER_SHIFT_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef ITER_SHIFT_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef ITER_SHIFT_OVF_EN
                    // Every bit leaves the word when the amount clamps.
                    ovf_d = amt_big ? (|in_data) : 1'b0;
`endif
                    if (amt_big) begin
                        data_d  = '0;
                        res_d   = '0;
                        state_d = S_DONE;
                    end else if (amt_zero) begin
                        data_d  = in_data;
                        res_d   = in_data;
                        state_d = S_DONE;
                    end else begin
                        // amt < WIDTH here, so the low CW bits carry all of it
                        data_d  = in_data;
                        cnt_d   = in_amt[CW-1:0];
                        state_d = S_SHIFT;
                    end
                end
            end
            S_SHIFT: begin
                data_d = {data_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q - 1'b1;
`ifdef ITER_SHIFT_OVF_EN
                ovf_d  = ovf_q | data_q[WIDTH-1];
`endif
                // Final shift publishes straight into the result register so
                // out_data never shows intermediate values.
                if (cnt_q == CW'(1)) begin
                    res_d   = {data_q[WIDTH-2:0], 1'b0};
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_data = res_q;
`ifdef ITER_SHIFT_OVF_EN
    assign out_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_iter_lshift_unit.sv
// ---------------------------------------------------------------------------
// tb_iter_lshift_unit
//
// Scoreboard bench for iter_lshift_unit. The expected result, overflow flag and
// latency are pushed when a request is driven. They are popped when out_valid
// rises. Inputs are driven on the falling edge. Outputs are sampled 1 time
// unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_iter_lshift_unit;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [7:0] in_amt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
`ifdef ITER_SHIFT_OVF_EN
    logic       out_ovf;
`endif

    iter_lshift_unit #(
        .WIDTH(8),
        .SHW  (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_amt   (in_amt),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
`ifdef ITER_SHIFT_OVF_EN
        ,
        .out_ovf  (out_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       ovf;
        int         lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model built from whole-word arithmetic, not step by step.
    function automatic exp_t model(input logic [7:0] d, input logic [7:0] a);
        exp_t        e;
        logic [15:0] wide;
        wide = {8'd0, d};
        if (a >= 8'd8) begin
            e.data = 8'h00;
            e.ovf  = |d;
            e.lat  = 1;
        end else if (a == 8'd0) begin
            e.data = d;
            e.ovf  = 1'b0;
            e.lat  = 1;
        end else begin
            e.data = 8'(wide << a);
            e.ovf  = |(wide >> (8 - a));
            e.lat  = int'(a) + 1;
        end
        return e;
    endfunction

    // Sends one request, waits for the result, applies hold cycles of
    // backpressure, and then completes the output handshake.
    task automatic do_req(input logic [7:0] d, input logic [7:0] a, input int hold);
        exp_t e;
        int   edges;
        logic [7:0] held;
        @(negedge clk);
        check_val("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_data   = d;
        in_amt    = a;
        out_ready = (hold == 0);
        sb_q.push_back(model(d, a));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_amt   = 8'h00;
        edges    = 1;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        e = sb_q.pop_front();
        if (!out_valid) begin
            check_val("timeout", 32'(out_valid), 32'd1);
        end else begin
            check_val("latency", 32'(edges), 32'(e.lat));
            check_val("out_data", 32'(out_data), 32'(e.data));
`ifdef ITER_SHIFT_OVF_EN
            check_val("out_ovf", 32'(out_ovf), 32'(e.ovf));
`endif
        end
        $display("txn data=%02h amt=%0d hold=%0d -> result=%02h lat=%0d", d, a, hold, out_data, edges);
        held = out_data;
        for (int i = 0; i < hold; i++) begin
            // A competing request must be ignored while the result is held.
            in_valid = 1'b1;
            in_data  = 8'hee;
            in_amt   = 8'd0;
            check_val("bp_valid", 32'(out_valid), 32'd1);
            check_val("bp_data", 32'(out_data), 32'(held));
            check_val("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_val("post_hs_valid", 32'(out_valid), 32'd0);
        check_val("post_hs_ready", 32'(in_ready), 32'd1);
        check_val("post_hs_data", 32'(out_data), 32'(held));
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_amt    = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_in_ready", 32'(in_ready), 32'd1);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_data", 32'(out_data), 32'd0);
`ifdef ITER_SHIFT_OVF_EN
        check_val("rst_out_ovf", 32'(out_ovf), 32'd0);
`endif
        reset = 1'b0;

        do_req(8'h01, 8'd0, 0);
        do_req(8'h01, 8'd7, 0);
        do_req(8'ha5, 8'd1, 0);
        do_req(8'ha5, 8'd7, 0);
        do_req(8'hff, 8'd9, 0);
        do_req(8'h5a, 8'd3, 5);
        do_req(8'h3c, 8'd8, 2);
        do_req(8'h81, 8'd200, 0);

        // Reset during SHIFT discards the operation.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h81;
        in_amt   = 8'd6;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("mid_shift_busy", 32'(in_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_val("midrst_in_ready", 32'(in_ready), 32'd1);
        check_val("midrst_out_valid", 32'(out_valid), 32'd0);
        check_val("midrst_out_data", 32'(out_data), 32'd0);
        $display("txn reset during shift data=81 amt=6 discarded");
        do_req(8'h03, 8'd2, 0);

        for (int k = 0; k < 12; k++) begin
            do_req(8'($urandom_range(0, 255)), 8'($urandom_range(0, 12)), int'($urandom_range(0, 2)));
        end

        check_val("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
